// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand-forwarding unit for an in-order MIPS-style pipeline.
// Tracks destination registers of in-flight stages and resolves RAW hazards by forwarding or stalling.
module hazard_fwd_unit #(
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16,
    localparam int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_inst,
    input  logic             id_valid,
    input  logic             flush,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs, rt, rd;
    logic       unused_shamt;

    assign opcode       = id_inst[31:26];
    assign rs           = id_inst[25:21];
    assign rt           = id_inst[20:16];
    assign rd           = id_inst[15:11];
    assign funct        = id_inst[5:0];
    assign unused_shamt = ^id_inst[10:6];

    logic       a_used, b_used, has_dest, id_is_load;
    logic [4:0] a_reg, b_reg, id_dest;

    always_comb begin
        a_used     = 1'b0;
        b_used     = 1'b0;
        has_dest   = 1'b0;
        id_is_load = 1'b0;
        a_reg      = rs;
        b_reg      = rt;
        id_dest    = rd;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_SLT: begin
                        a_used   = 1'b1;
                        b_used   = 1'b1;
                        has_dest = 1'b1;
                    end
                    FN_SLL, FN_SRL: begin
                        // Shifts take their data operand from rt, routed onto port A.
                        a_used   = 1'b1;
                        a_reg    = rt;
                        has_dest = 1'b1;
                    end
                    FN_JR: a_used = 1'b1;
                    default: ;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_LW: begin
                a_used     = 1'b1;
                has_dest   = 1'b1;
                id_dest    = rt;
                id_is_load = (opcode == OP_LW);
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                a_used = 1'b1;
                b_used = 1'b1;
            end
            OP_JAL: begin
                has_dest = 1'b1;
                id_dest  = 5'd31;
            end
            OP_J:    ;
            default: ;
        endcase
    end

    // Scoreboard: bit/element 0 is EXE, DEPTH-1 is WB.
    logic [DEPTH-1:0]      valid_reg;
    logic [DEPTH-1:0]      load_reg;
    logic [DEPTH-1:0][4:0] dest_reg;
    logic [CNT_W-1:0]      stall_count_reg;

    logic [DEPTH-1:0] a_hit, b_hit;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign a_hit[gi] = a_used && (a_reg != 5'd0) && valid_reg[gi] && (dest_reg[gi] == a_reg);
            assign b_hit[gi] = b_used && (b_reg != 5'd0) && valid_reg[gi] && (dest_reg[gi] == b_reg);
        end
    endgenerate

    logic [SEL_W-1:0] a_sel_raw, b_sel_raw;

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        a_sel_raw = '0;
        b_sel_raw = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (a_hit[k]) a_sel_raw = SEL_W'(k + 1);
            if (b_hit[k]) b_sel_raw = SEL_W'(k + 1);
        end
    end

    logic hazard, push;

    always_comb begin
        if (FWD_EN != 0)
            hazard = (a_hit[0] || b_hit[0]) && load_reg[0];
        else
            hazard = (|a_hit) || (|b_hit);
        stall = !rst && id_valid && !flush && hazard;
        if ((FWD_EN != 0) && !rst && !stall) begin
            fwd_a_sel = a_sel_raw;
            fwd_b_sel = b_sel_raw;
        end else begin
            fwd_a_sel = '0;
            fwd_b_sel = '0;
        end
        push = id_valid && !stall && !flush && has_dest && (id_dest != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg       <= '0;
            load_reg        <= '0;
            dest_reg        <= '0;
            stall_count_reg <= '0;
        end else begin
            valid_reg <= {valid_reg[DEPTH-2:0], push};
            load_reg  <= {load_reg[DEPTH-2:0], id_is_load};
            dest_reg  <= {dest_reg[DEPTH-2:0], id_dest};
            if (stall && (stall_count_reg != {CNT_W{1'b1}}))
                stall_count_reg <= stall_count_reg + 1'b1;
        end
    end

    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench: one forwarding instance and one stall-only instance with a 2-bit counter.
module tb_hazard_fwd_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_valid, a_flush;
    logic [31:0] a_inst;
    logic        a_stall;
    logic [1:0]  a_fa, a_fb;
    logic [15:0] a_cnt;

    logic        b_rst, b_valid, b_flush;
    logic [31:0] b_inst;
    logic        b_stall;
    logic [1:0]  b_fa, b_fb;
    logic [1:0]  b_cnt;

    hazard_fwd_unit #(.DEPTH(3), .FWD_EN(1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst(a_rst), .id_inst(a_inst), .id_valid(a_valid), .flush(a_flush),
        .stall(a_stall), .fwd_a_sel(a_fa), .fwd_b_sel(a_fb), .stall_count(a_cnt)
    );

    hazard_fwd_unit #(.DEPTH(3), .FWD_EN(0), .CNT_W(2)) u_stl (
        .clk(clk), .rst(b_rst), .id_inst(b_inst), .id_valid(b_valid), .flush(b_flush),
        .stall(b_stall), .fwd_a_sel(b_fa), .fwd_b_sel(b_fb), .stall_count(b_cnt)
    );

    typedef struct {
        string name;
        int    unit;
        int    stall;
        int    fa;
        int    fb;
        int    cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] rtype(input int funct, input int rs, input int rt, input int rd);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic step(input string name, input int unit, input logic rst, input logic valid,
                        input logic fl, input logic [31:0] inst,
                        input int e_stall, input int e_fa, input int e_fb, input int e_cnt);
        exp_t e;
        logic [31:0] g_stall, g_fa, g_fb, g_cnt;
        if (unit == 0) begin
            a_rst = rst; a_valid = valid; a_flush = fl; a_inst = inst;
        end else begin
            b_rst = rst; b_valid = valid; b_flush = fl; b_inst = inst;
        end
        exp_q.push_back('{name, unit, e_stall, e_fa, e_fb, e_cnt});
        @(negedge clk);
        e = exp_q.pop_front();
        if (e.unit == 0) begin
            g_stall = 32'(a_stall); g_fa = 32'(a_fa); g_fb = 32'(a_fb); g_cnt = 32'(a_cnt);
        end else begin
            g_stall = 32'(b_stall); g_fa = 32'(b_fa); g_fb = 32'(b_fb); g_cnt = 32'(b_cnt);
        end
        $display("%s u%0d inst=%h stall=%0d fa=%0d fb=%0d cnt=%0d", e.name, e.unit, inst,
                 g_stall, g_fa, g_fb, g_cnt);
        check_eq({e.name, ".stall"}, g_stall, 32'(e.stall));
        check_eq({e.name, ".fwd_a"}, g_fa, 32'(e.fa));
        check_eq({e.name, ".fwd_b"}, g_fb, 32'(e.fb));
        check_eq({e.name, ".count"}, g_cnt, 32'(e.cnt));
        @(posedge clk);
        #1;
    endtask

    localparam int F_ADD = 'h20, F_SUB = 'h22, F_SLL = 'h00, F_JR = 'h08;
    localparam int O_ADDI = 'h08, O_LW = 'h23, O_SW = 'h2B, O_BEQ = 'h04, O_JAL = 'h03;

    initial begin
        a_rst = 1'b1; a_valid = 1'b0; a_flush = 1'b0; a_inst = '0;
        b_rst = 1'b1; b_valid = 1'b0; b_flush = 1'b0; b_inst = '0;
        repeat (2) @(posedge clk);
        #1;

        // Forwarding instance
        step("a_reset",      0, 1, 0, 0, rtype(F_ADD, 1, 1, 2),     0, 0, 0, 0);
        step("a_addi1",      0, 0, 1, 0, itype(O_ADDI, 0, 1, 5),    0, 0, 0, 0);
        step("a_add2_fwd",   0, 0, 1, 0, rtype(F_ADD, 1, 1, 2),     0, 1, 1, 0);
        step("a_sub3_fwd",   0, 0, 1, 0, rtype(F_SUB, 0, 1, 3),     0, 0, 2, 0);
        step("a_lw3",        0, 0, 1, 0, itype(O_LW, 0, 3, 0),      0, 0, 0, 0);
        step("a_loaduse",    0, 0, 1, 0, rtype(F_ADD, 3, 0, 4),     1, 0, 0, 0);
        step("a_loaduse_go", 0, 0, 1, 0, rtype(F_ADD, 3, 0, 4),     0, 2, 0, 1);
        step("a_addi_r0",    0, 0, 1, 0, itype(O_ADDI, 0, 0, 7),    0, 0, 0, 1);
        step("a_add_r0",     0, 0, 1, 0, rtype(F_ADD, 0, 0, 5),     0, 0, 0, 1);
        step("a_addi6a",     0, 0, 1, 0, itype(O_ADDI, 0, 6, 1),    0, 0, 0, 1);
        step("a_addi6b",     0, 0, 1, 0, itype(O_ADDI, 0, 6, 2),    0, 0, 0, 1);
        step("a_youngest",   0, 0, 1, 0, rtype(F_ADD, 6, 0, 7),     0, 1, 0, 1);
        step("a_lw8",        0, 0, 1, 0, itype(O_LW, 0, 8, 0),      0, 0, 0, 1);
        step("a_flush",      0, 0, 1, 1, rtype(F_ADD, 8, 8, 9),     0, 1, 1, 1);
        step("a_after_fl",   0, 0, 0, 0, 32'd0,                     0, 0, 0, 1);
        step("a_sll_wb",     0, 0, 1, 0, rtype(F_SLL, 0, 8, 10),    0, 3, 0, 1);
        step("a_sw_b",       0, 0, 1, 0, itype(O_SW, 0, 10, 4),     0, 0, 1, 1);
        step("a_jal",        0, 0, 1, 0, {6'(O_JAL), 26'd0},        0, 0, 0, 1);
        step("a_jr31",       0, 0, 1, 0, rtype(F_JR, 31, 0, 0),     0, 1, 0, 1);
        step("a_lw12",       0, 0, 1, 0, itype(O_LW, 0, 12, 0),     0, 0, 0, 1);
        step("a_beq_lu",     0, 0, 1, 0, itype(O_BEQ, 0, 12, 1),    1, 0, 0, 1);
        step("a_beq_go",     0, 0, 1, 0, itype(O_BEQ, 0, 12, 1),    0, 0, 2, 2);
        step("a_lw13",       0, 0, 1, 0, itype(O_LW, 0, 13, 0),     0, 0, 0, 2);
        step("a_rst_lu",     0, 1, 1, 0, rtype(F_ADD, 13, 0, 14),   0, 0, 0, 2);
        step("a_post_rst",   0, 0, 1, 0, rtype(F_ADD, 13, 0, 14),   0, 0, 0, 0);

        // Stall-only instance, 2-bit counter
        step("b_reset",      1, 1, 0, 0, 32'd0,                     0, 0, 0, 0);
        step("b_addi1",      1, 0, 1, 0, itype(O_ADDI, 0, 1, 1),    0, 0, 0, 0);
        step("b_beq_st1",    1, 0, 1, 0, itype(O_BEQ, 1, 0, 3),     1, 0, 0, 0);
        step("b_beq_st2",    1, 0, 1, 0, itype(O_BEQ, 1, 0, 3),     1, 0, 0, 1);
        step("b_beq_st3",    1, 0, 1, 0, itype(O_BEQ, 1, 0, 3),     1, 0, 0, 2);
        step("b_beq_go",     1, 0, 1, 0, itype(O_BEQ, 1, 0, 3),     0, 0, 0, 3);
        step("b_addi2",      1, 0, 1, 0, itype(O_ADDI, 0, 2, 1),    0, 0, 0, 3);
        step("b_sat1",       1, 0, 1, 0, rtype(F_ADD, 2, 2, 3),     1, 0, 0, 3);
        step("b_sat2",       1, 0, 1, 0, rtype(F_ADD, 2, 2, 3),     1, 0, 0, 3);
        step("b_sat3",       1, 0, 1, 0, rtype(F_ADD, 2, 2, 3),     1, 0, 0, 3);
        step("b_sat_go",     1, 0, 1, 0, rtype(F_ADD, 2, 2, 3),     0, 0, 0, 3);
        step("b_st_pre_rst", 1, 0, 1, 0, rtype(F_ADD, 3, 0, 4),     1, 0, 0, 3);
        step("b_rst_mid",    1, 1, 1, 0, rtype(F_ADD, 3, 0, 4),     0, 0, 0, 3);
        step("b_post_rst",   1, 0, 1, 0, rtype(F_ADD, 3, 0, 4),     0, 0, 0, 0);
        step("b_addi5",      1, 0, 1, 0, itype(O_ADDI, 0, 5, 1),    0, 0, 0, 0);
        step("b_flush",      1, 0, 1, 1, rtype(F_ADD, 5, 0, 6),     0, 0, 0, 0);
        step("b_novalid",    1, 0, 0, 0, rtype(F_ADD, 5, 0, 6),     0, 0, 0, 0);
        step("b_cnt_hold",   1, 0, 0, 0, 32'd0,                     0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
